// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: sole owner of the register-file write port; round-robin writeback arbiter with x1..x31 zero-init sweep
//   i_clk        clock, all state on rising edge
//   i_rst        synchronous active-low reset
//   i_clear      request a re-initialisation sweep (honoured only in RUN)
//   i_req_valid  per-requester write request
//   i_req_rd     flattened 5-bit destination indices, requester i at [5i+4:5i]
//   i_req_data   flattened write data, requester i at [DATA_W*i +: DATA_W]
//   o_req_ready  one-hot grant, combinational
//   o_wb_we      registered register-file write enable
//   o_wb_rw      registered register-file write address
//   o_wb_w       registered register-file write data
//   o_init_busy  high while the init sweep runs
module regfile_wb_arbiter #(
   parameter int NREQ   = 3,
   parameter int DATA_W = 64
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_clear,
   input  logic [NREQ-1:0]        i_req_valid,
   input  logic [5*NREQ-1:0]      i_req_rd,
   input  logic [DATA_W*NREQ-1:0] i_req_data,
   output logic [NREQ-1:0]        o_req_ready,
   output logic                   o_wb_we,
   output logic [4:0]             o_wb_rw,
   output logic [DATA_W-1:0]      o_wb_w,
   output logic                   o_init_busy
);
   localparam int PW = $clog2(NREQ);
   typedef enum logic {INIT, RUN} state_t;
   state_t            r_state, w_next;
   logic [4:0]        r_cnt;
   logic [PW-1:0]     r_ptr, w_idx, w_gidx, w_ptr_nx;
   logic              w_hit, w_xfer;
   logic              r_we;
   logic [4:0]        r_rw;
   logic [DATA_W-1:0] r_w;
   logic [4:0]        w_rd;
   logic [DATA_W-1:0] w_data;
   logic [4:0]        w_rd_a   [NREQ];
   logic [DATA_W-1:0] w_data_a [NREQ];
   genvar g;
   generate
      for (g = 0; g < NREQ; g++) begin : g_unpack
         assign w_rd_a[g]   = i_req_rd[5*g +: 5];
         assign w_data_a[g] = i_req_data[DATA_W*g +: DATA_W];
      end
   endgenerate
   // first valid requester at or after the pointer, wrapping modulo NREQ
   always_comb begin
      w_hit  = 1'b0;
      w_gidx = r_ptr;
      w_idx  = r_ptr;
      for (int k = 0; k < NREQ; k++) begin
         w_idx = PW'((int'(r_ptr) + k) % NREQ);
         if (!w_hit && i_req_valid[w_idx]) begin
            w_hit  = 1'b1;
            w_gidx = w_idx;
         end
      end
   end
   // clear suppresses every grant in the cycle it is seen
   assign w_xfer   = (r_state == RUN) && !i_clear && w_hit;
   assign w_rd     = w_rd_a[w_gidx];
   assign w_data   = w_data_a[w_gidx];
   assign w_ptr_nx = (w_gidx == PW'(NREQ-1)) ? '0 : w_gidx + 1'b1;
   always_ff @(posedge i_clk) begin
      if (!i_rst) r_state <= INIT;
      else        r_state <= w_next;
   end
   always_comb begin
      w_next = r_state;
      if (r_state == INIT) w_next = (r_cnt == 5'd31) ? RUN : INIT;
      else                 w_next = i_clear ? INIT : RUN;
   end
   always_comb begin
      o_req_ready = w_xfer ? (NREQ'(1) << w_gidx) : '0;
      o_init_busy = (r_state == INIT);
      o_wb_we     = r_we;
      o_wb_rw     = r_rw;
      o_wb_w      = r_w;
   end
   // writes to x0 complete the handshake but never reach the register file
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_cnt <= 5'd1;
         r_ptr <= '0;
         r_we  <= 1'b0;
         r_rw  <= '0;
         r_w   <= '0;
      end else if (r_state == INIT) begin
         r_we  <= 1'b1;
         r_rw  <= r_cnt;
         r_w   <= '0;
         r_cnt <= (r_cnt == 5'd31) ? 5'd1 : r_cnt + 5'd1;
      end else begin
         r_we <= w_xfer && (w_rd != 5'd0);
         if (w_xfer) r_ptr <= w_ptr_nx;
         if (w_xfer && (w_rd != 5'd0)) begin
            r_rw <= w_rd;
            r_w  <= w_data;
         end
         if (i_clear) r_cnt <= 5'd1;
      end
   end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed and randomized checks of regfile_wb_arbiter against a behavioural model
module tb_regfile_wb_arbiter;
   localparam int NREQ = 3;
   localparam int DW   = 64;
   logic            clk = 1'b0;
   logic            rst;
   logic            clear;
   logic [NREQ-1:0] valid;
   logic [5*NREQ-1:0]  rd;
   logic [DW*NREQ-1:0] data;
   logic [NREQ-1:0] ready;
   logic            wb_we;
   logic [4:0]      wb_rw;
   logic [DW-1:0]   wb_w;
   logic            busy;
   int n_chk = 0;
   int n_err = 0;
   bit        m_ok = 0;
   bit        m_sweep;
   int        m_next;
   int        m_ptr;
   bit        e_we;
   int        e_rw;
   logic [DW-1:0] e_w;
   bit        rec = 0;
   int        sw_q[$];
   logic [NREQ-1:0] last_ready;
   always #5 clk = ~clk;
   regfile_wb_arbiter #(.NREQ(NREQ), .DATA_W(DW)) dut (
      .i_clk(clk), .i_rst(rst), .i_clear(clear), .i_req_valid(valid),
      .i_req_rd(rd), .i_req_data(data), .o_req_ready(ready), .o_wb_we(wb_we),
      .o_wb_rw(wb_rw), .o_wb_w(wb_w), .o_init_busy(busy)
   );
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s got=%h want=%h t=%0t", tag, obs, exp, $time);
      end
   endtask
   task automatic model_reset();
      m_sweep = 1; m_next = 1; m_ptr = 0;
      e_we = 0; e_rw = 0; e_w = '0;
   endtask
   task automatic cyc();
      int gi;
      logic [NREQ-1:0] er;
      logic [4:0] grd;
      @(negedge clk);
      gi = -1;
      if (!m_sweep && !clear)
         for (int off = 0; off < NREQ; off++) begin
            int c;
            c = (m_ptr + off) % NREQ;
            if (gi < 0 && valid[c]) gi = c;
         end
      er = '0;
      if (gi >= 0) er[gi] = 1'b1;
      if (m_ok) begin
         chk("ready", 64'(ready), 64'(er));
         chk("busy", 64'(busy), 64'(m_sweep));
         chk("we", 64'(wb_we), 64'(e_we));
         if (e_we) begin
            chk("rw", 64'(wb_rw), 64'(e_rw));
            chk("w", wb_w, e_w);
         end
      end
      last_ready = ready;
      if (rec && wb_we) sw_q.push_back(int'(wb_rw));
      if (!rst) model_reset();
      else if (m_sweep) begin
         e_we = 1; e_rw = m_next; e_w = '0;
         if (m_next == 31) begin m_sweep = 0; m_next = 1; end
         else m_next++;
      end else if (clear) begin
         m_sweep = 1; m_next = 1; e_we = 0;
      end else if (gi >= 0) begin
         grd  = rd[5*gi +: 5];
         e_we = (grd != 0);
         if (grd != 0) begin e_rw = grd; e_w = data[DW*gi +: DW]; end
         m_ptr = (gi + 1) % NREQ;
      end else e_we = 0;
      @(posedge clk);
      #1;
   endtask
   task automatic idle();
      clear = 0; valid = '0;
   endtask
   initial begin
      rst = 0; clear = 0; valid = '0; rd = '0; data = '0;
      @(posedge clk);
      #1;
      model_reset();
      m_ok = 1;
      chk("rst_we", 64'(wb_we), 64'd0);
      chk("rst_busy", 64'(busy), 64'd1);
      cyc();
      rst = 1;
      sw_q.delete(); rec = 1;
      for (int i = 0; i < 34; i++) begin
         valid = (i == 10) ? 3'b111 : 3'b000;
         cyc();
      end
      rec = 0;
      idle();
      chk("sweep_len", 64'(sw_q.size()), 64'd31);
      for (int i = 0; i < sw_q.size() && i < 31; i++) chk("sweep_addr", 64'(sw_q[i]), 64'(i + 1));
      valid = 3'b010; rd[9:5] = 5'd5; data[127:64] = 64'hDEAD_BEEF_0000_0001;
      cyc();
      chk("single_ready", 64'(last_ready), 64'b010);
      chk("single_we", 64'(wb_we), 64'd1);
      chk("single_rw", 64'(wb_rw), 64'd5);
      chk("single_w", wb_w, 64'hDEAD_BEEF_0000_0001);
      idle();
      cyc();
      chk("single_we_off", 64'(wb_we), 64'd0);
      valid = 3'b100; rd[14:10] = 5'd7; data[191:128] = 64'h77;
      cyc();
      valid = 3'b111;
      rd = {5'd3, 5'd2, 5'd1};
      data = {64'hC, 64'hB, 64'hA};
      sw_q.delete(); rec = 1;
      for (int i = 0; i < 6; i++) begin
         cyc();
         chk("rr_onehot", 64'($countones(last_ready)), 64'd1);
         chk("rr_grant", 64'(last_ready), 64'(3'b001 << (i % 3)));
      end
      idle();
      cyc();
      rec = 0;
      chk("rr_len", 64'(sw_q.size()), 64'd7);
      for (int i = 1; i < sw_q.size(); i++) chk("rr_rw", 64'(sw_q[i]), 64'((i - 1) % 3 + 1));
      valid = 3'b001; rd[4:0] = 5'd0; data[63:0] = 64'hFF;
      cyc();
      chk("x0_ready", 64'(last_ready), 64'b001);
      chk("x0_we", 64'(wb_we), 64'd0);
      valid = 3'b101; rd[4:0] = 5'd4; rd[14:10] = 5'd6;
      cyc();
      chk("x0_ptr", 64'(last_ready), 64'b100);
      valid = 3'b100; clear = 1;
      cyc();
      chk("clr_ready", 64'(last_ready), 64'b000);
      clear = 0;
      for (int i = 0; i < 32; i++) cyc();
      cyc();
      chk("clr_grant_after", 64'(last_ready), 64'b100);
      idle();
      clear = 1;
      cyc();
      clear = 0;
      begin
         bit seen;
         seen = 0;
         for (int i = 0; i < 40 && !seen; i++) begin
            cyc();
            if (wb_we && wb_rw == 5'd10) seen = 1;
         end
         chk("x10_seen", 64'(seen), 64'd1);
      end
      rst = 0;
      cyc();
      chk("midrst_we", 64'(wb_we), 64'd0);
      rst = 1;
      sw_q.delete(); rec = 1;
      for (int i = 0; i < 3; i++) cyc();
      rec = 0;
      chk("midrst_restart", 64'(sw_q.size() > 0 ? sw_q[0] : -1), 64'd1);
      for (int i = 0; i < 600; i++) begin
         valid = NREQ'($urandom);
         for (int r = 0; r < NREQ; r++) begin
            rd[5*r +: 5] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            data[DW*r +: DW] = {$urandom, $urandom};
         end
         clear = ($urandom_range(0, 59) == 0);
         rst = ($urandom_range(0, 249) != 0);
         cyc();
      end
      rst = 1; idle();
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
